// File: rtl/ones_frame_gen.sv
// Serial thermometer-frame generator: takes a ones count K and emits an N-bit
// frame with min(K,N) ones packed LSB-first, then presents it as a parallel word.
module ones_frame_gen #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [CW-1:0] in_count_i,
  output logic          in_ready_o,
  output logic          ser_out_o,
  output logic          ser_valid_o,
  input  logic          ser_ready_i,
  output logic          ser_first_o,
  output logic          ser_last_o,
  output logic [N-1:0]  par_out_o,
  output logic          par_valid_o,
  output logic          sat_o
);

  localparam int IW = $clog2(N);
  localparam logic [CW:0]   N_W    = (CW+1)'(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N-1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW:0]   keff_q, keff_d;
  logic          sat_q, sat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  asm_q, asm_d;
  logic [N-1:0]  par_q, par_d;

  logic [CW:0]   idx_ext;
  logic [CW:0]   cnt_ext;
  logic          over;
  logic          cur_bit;

  // Compare in CW+1 bits so K near 2^CW never wraps against N or the index.
  assign idx_ext = (CW+1)'(idx_q);
  assign cnt_ext = {1'b0, in_count_i};
  assign over    = cnt_ext > N_W;
  assign cur_bit = idx_ext < keff_q;

  always_comb begin
    state_d     = state_q;
    keff_d      = keff_q;
    sat_d       = sat_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    par_d       = par_q;
    in_ready_o  = 1'b0;
    ser_valid_o = 1'b0;
    ser_out_o   = 1'b0;
    ser_first_o = 1'b0;
    ser_last_o  = 1'b0;
    par_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          keff_d  = over ? N_W : cnt_ext;
          sat_d   = over;
          idx_d   = '0;
          asm_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        ser_valid_o = 1'b1;
        ser_out_o   = cur_bit;
        ser_first_o = (idx_q == '0);
        ser_last_o  = (idx_q == IDX_LAST);
        if (ser_ready_i) begin
          asm_d[idx_q] = cur_bit;
          if (idx_q == IDX_LAST) begin
            // Publish on the DONE cycle so par_out and par_valid line up.
            par_d   = asm_d;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        par_valid_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      keff_q  <= '0;
      sat_q   <= 1'b0;
      idx_q   <= '0;
      asm_q   <= '0;
      par_q   <= '0;
    end else begin
      state_q <= state_d;
      keff_q  <= keff_d;
      sat_q   <= sat_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      par_q   <= par_d;
    end
  end

  assign par_out_o = par_q;
  assign sat_o     = sat_q;

endmodule

// File: tb/tb_ones_frame_gen.sv
// Randomized self-checking bench for ones_frame_gen against a frame-level model.
module tb_ones_frame_gen;
  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_count;
  logic          in_ready;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_ready;
  logic          ser_first;
  logic          ser_last;
  logic [N-1:0]  par_out;
  logic          par_valid;
  logic          sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ones_frame_gen #(.N(N), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_count_i(in_count),
    .in_ready_o(in_ready), .ser_out_o(ser_out), .ser_valid_o(ser_valid),
    .ser_ready_i(ser_ready), .ser_first_o(ser_first), .ser_last_o(ser_last),
    .par_out_o(par_out), .par_valid_o(par_valid), .sat_o(sat)
  );

  // mode 0: ser_ready always high; 1: random; 2: pattern 1,0,0,1,0,0,...
  task automatic run_frame(input int k, input int mode, input bit poke, input string nm);
    int keff, nb, cyc, waitc;
    bit exp_sat, rdy;
    logic [N-1:0] exp_frame;
    logic [4:0] exp_ser, got_ser;
    keff      = (k > N) ? N : k;
    exp_sat   = (k > N);
    exp_frame = N'((64'd1 << keff) - 64'd1);
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_wait: in_ready=%b required 1", nm, in_ready);
      return;
    end
    in_valid  = 1'b1;
    in_count  = CW'(k);
    ser_ready = (mode == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_count = CW'($urandom);
    nb  = 0;
    cyc = 1;
    while (nb < N && cyc < 200) begin
      exp_ser = {1'b1, 1'b0, (nb < keff), (nb == 0), (nb == N-1)};
      got_ser = {ser_valid, in_ready, ser_out, ser_first, ser_last};
      checks++;
      if (got_ser !== exp_ser) begin
        errors++;
        $display("FAIL %s bit%0d cyc%0d {valid,ready,out,first,last}: got %b required %b",
                 nm, nb, cyc, got_ser, exp_ser);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = ((cyc - 1) % 3 == 0);
      endcase
      ser_ready = rdy;
      if (poke && (cyc % 2 == 0)) begin
        in_valid = 1'b1;
        in_count = 4'd2;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (rdy) nb++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (nb != N) begin
      errors++;
      $display("FAIL %s frame_timeout: bits=%0d required %0d", nm, nb, N);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != N + 1) begin
        errors++;
        $display("FAIL %s latency: done at T+%0d required T+%0d", nm, cyc, N + 1);
      end
    end
    checks++;
    if ({par_valid, ser_valid, in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL %s done_flags {par_valid,ser_valid,in_ready}: got %b required 100",
               nm, {par_valid, ser_valid, in_ready});
    end
    checks++;
    if (par_out !== exp_frame) begin
      errors++;
      $display("FAIL %s par_out: got %h required %h", nm, par_out, exp_frame);
    end
    checks++;
    if ($countones(par_out) != keff) begin
      errors++;
      $display("FAIL %s popcount: got %0d required %0d", nm, $countones(par_out), keff);
    end
    checks++;
    if (sat !== exp_sat) begin
      errors++;
      $display("FAIL %s sat: got %b required %b", nm, sat, exp_sat);
    end
    ser_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({par_valid, in_ready, sat, par_out} !== {1'b0, 1'b1, exp_sat, exp_frame}) begin
      errors++;
      $display("FAIL %s after_done {pv,rdy,sat,par}: got %b_%b_%b_%h required 0_1_%b_%h",
               nm, par_valid, in_ready, sat, par_out, exp_sat, exp_frame);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, ser_valid, ser_out, ser_first, ser_last, par_valid, sat, par_out} !==
        {1'b1, 6'b0, {N{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b sv=%b so=%b sf=%b sl=%b pv=%b sat=%b par=%h required 1,0,0,0,0,0,0,00",
               in_ready, ser_valid, ser_out, ser_first, ser_last, par_valid, sat, par_out);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, ser_valid, par_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_idle: {rdy,sv,pv}=%b required 100", {in_ready, ser_valid, par_valid});
    end
  endtask

  task automatic test_k3();
    run_frame(3, 0, 1'b0, "k3");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, 1'b0, "b2b_k0");
    run_frame(8, 0, 1'b0, "b2b_k8");
  endtask

  task automatic test_saturate();
    run_frame(12, 0, 1'b0, "sat_k12");
    run_frame(5, 0, 1'b0, "sat_clear_k5");
  endtask

  task automatic test_stall();
    run_frame(5, 2, 1'b1, "stall_k5");
  endtask

  task automatic test_reset_mid();
    logic [N+6:0] got;
    in_valid  = 1'b1;
    in_count  = 4'd6;
    ser_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ser_valid, ser_out, ser_first} !== 3'b110) begin
      errors++;
      $display("FAIL rst_mid bit3: {sv,so,sf}=%b required 110", {ser_valid, ser_out, ser_first});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {in_ready, ser_valid, ser_out, ser_first, ser_last, par_valid, sat, par_out};
    checks++;
    if (got !== {1'b1, 6'b0, {N{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid outputs: got %b required %b", got, {1'b1, 6'b0, {N{1'b0}}});
    end
    @(negedge clk);
    checks++;
    if (par_valid !== 1'b0 || par_out !== '0) begin
      errors++;
      $display("FAIL rst_mid no_pulse: pv=%b par=%h required 0,00", par_valid, par_out);
    end
    run_frame(1, 0, 1'b0, "rst_mid_k1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_frame(int'($urandom_range(0, 15)), 1, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_count  = '0;
    ser_ready = 1'b1;
    test_reset();
    test_k3();
    test_back_to_back();
    test_saturate();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ones_frame_gen.md
Name: ones_frame_gen

Overview:
- Inverse of the team's combinational ones-counter: accepts a population count K and serially emits an N-bit frame containing exactly K ones.
- Ones are packed LSB-first, giving a thermometer pattern.
- Also delivers the completed frame as a parallel word, so a downstream ones-counter must read back K.
- Sits between count-producing logic and any serial link or test-pattern consumer. Single clock domain.

Parameters:
- N, 8, frame width in bits (N >= 2).
- CW, 4, count field width; must satisfy 2^CW > N (default covers 0..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  count request valid.
- in_count  input  CW  requested number of ones K.
- in_ready  output  1  block can accept a request (high only in IDLE).
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream accepts the current bit.
- ser_first  output  1  current bit is frame bit 0.
- ser_last  output  1  current bit is frame bit N-1.
- par_out  output  N  completed frame; held until the next frame completes.
- par_valid  output  1  one-cycle pulse when par_out updates.
- sat  output  1  last accepted K exceeded N (K was clamped).

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; in_ready=1; ser_out=0; ser_valid=0; ser_first=0; ser_last=0; par_out=0; par_valid=0; sat=0; bit index=0.
- Reset has priority over every other event and aborts a frame mid-transfer: no par_valid, partial frame discarded, par_out cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch Keff=min(in_count,N), set sat=(in_count>N), index=0, go to SEND.
  - SEND: ser_valid=1, in_ready=0, ser_out=(index<Keff), ser_first=(index==0), ser_last=(index==N-1).
    - A bit transfers on a cycle with ser_valid&ser_ready; index then increments.
    - Transferred bits are shifted into an internal N-bit assembly register at position index.
    - Without ser_ready, all serial outputs hold stable (no change of ser_out or index).
    - When the bit with index N-1 transfers, go to DONE.
  - DONE (1 cycle): ser_valid=0, in_ready=0; par_out<=assembled frame; par_valid=1 this cycle only. Next state IDLE.
- Latency:
  - Request accepted at edge T; bit 0 is valid after edge T (cycle T+1).
  - With ser_ready held high, the last bit is in cycle T+N and par_valid is in cycle T+N+1.
  - in_ready returns in cycle T+N+2. Back-to-back throughput is one frame per N+2 cycles.
- Arithmetic:
  - Comparison index<Keff uses CW+1 bits, so no wrap occurs.
  - Index counter is $clog2(N) bits wide, never exceeds N-1, and resets to 0 on frame accept.
- Boundaries:
  - K=0 gives an all-zero frame.
  - K=N gives an all-one frame.
  - K>N gives an all-one frame with sat=1. sat holds until the next accept, which updates it.
  - in_valid asserted outside IDLE is ignored (not latched); in_count changes during SEND have no effect.
  - ser_ready may toggle arbitrarily; frame content and order are unaffected.
- Invariant: popcount(par_out)==Keff for every par_valid pulse.

Test Plan:
- Reset then idle: rst 2 cycles -> in_ready=1, ser_valid=0, par_out=0, sat=0.
- K=3, N=8, ser_ready=1:
  - serial bits 1,1,1,0,0,0,0,0.
  - ser_first in cycle T+1, ser_last in cycle T+8.
  - par_valid pulse in T+9 with par_out=8'h07.
  - in_ready high at T+10.
- K=0 and K=8 back-to-back -> par_out=8'h00 then 8'hFF; sat=0 for both.
- K=12 (>N) -> all-ones frame, par_out=8'hFF, sat=1. Next request K=5 clears sat and gives par_out=8'h1F.
- K=5 with ser_ready toggling 1,0,0,1,... -> ser_out/index hold while ser_ready=0; final par_out=8'h1F. in_valid pulsed mid-frame with K=2 is ignored.
- K=6, rst asserted at bit index 3 -> next cycle all outputs at reset values, no par_valid, par_out=0. New K=1 afterwards gives par_out=8'h01.
